// File: rtl/pkt_rx_consumer.sv
// Length/payload/checksum packet parser. Payload bytes go out through a one-deep
// registered output stage with valid/ready; a verdict pulse and counters follow each packet.
module pkt_rx_consumer #(
  parameter int MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        pkt_ok,
  output logic        pkt_err,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {S_LEN, S_PAY, S_SUM} state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_LEN);

  state_t      r_state;
  logic [7:0]  r_rem;
  logic [7:0]  r_sum;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_ok;
  logic        r_err;
  logic [15:0] r_pkt_count;
  logic [15:0] r_err_count;

  logic w_in_ready;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_len_bad;

  // Payload may only advance when the output register is free or draining this cycle.
  assign w_in_ready = (r_state != S_PAY) || !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && w_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_len_bad  = (in_data == 8'd0) || (in_data > LP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LEN;
      r_rem       <= 8'd0;
      r_sum       <= 8'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_pkt_count <= 16'd0;
      r_err_count <= 16'd0;
    end else begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      case (r_state)
        S_LEN: if (w_in_xfer) begin
          if (w_len_bad) begin
            r_err <= 1'b1;
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          end else begin
            r_rem   <= in_data;
            r_sum   <= 8'd0;
            r_state <= S_PAY;
          end
        end
        S_PAY: if (w_in_xfer) begin
          // A same-cycle output transfer is overridden here, so the stage refills without a bubble.
          r_out_data  <= in_data;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_rem == 8'd1);
          r_sum       <= r_sum + in_data;
          r_rem       <= r_rem - 8'd1;
          if (r_rem == 8'd1) r_state <= S_SUM;
        end
        S_SUM: if (w_in_xfer) begin
          if (in_data == r_sum) begin
            r_ok <= 1'b1;
            if (r_pkt_count != 16'hFFFF) r_pkt_count <= r_pkt_count + 16'd1;
          end else begin
            r_err <= 1'b1;
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          end
          r_state <= S_LEN;
        end
        default: r_state <= S_LEN;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign pkt_ok    = r_ok;
  assign pkt_err   = r_err;
  assign pkt_count = r_pkt_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_pkt_rx_consumer.sv
// Scenario bench for pkt_rx_consumer: directed and random packet streams compared
// against a framing-level reference model of bytes, verdicts and counters.
module tb_pkt_rx_consumer;
  localparam int MAX_LEN = 15;
  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        pkt_ok;
  logic        pkt_err;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  int stalls = 0;
  int cyc = 0;
  bit rr = 1'b0;
  bit saw_ov = 1'b0;
  logic [8:0] obs_d[$], exp_d[$];
  logic [1:0] obs_v[$], exp_v[$];

  pkt_rx_consumer #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Inputs change 1 time unit after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) saw_ov = 1'b1;
      if (out_valid && out_ready) obs_d.push_back({out_last, out_data});
      if (pkt_ok || pkt_err) obs_v.push_back({pkt_err, pkt_ok});
    end
  end

  always @(posedge clk) begin
    #1;
    if (rr) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Reference: walk the byte stream by the framing rules.
  function automatic void model(input bq_t s);
    int i = 0;
    int len;
    int sum;
    while (i < s.size()) begin
      len = int'(s[i]);
      i++;
      if (len == 0 || len > MAX_LEN) begin
        exp_v.push_back(2'b10);
        exp_err = sat(exp_err + 1);
      end else begin
        sum = 0;
        for (int j = 0; j < len; j++) begin
          exp_d.push_back({(j == len - 1), s[i]});
          sum = (sum + int'(s[i])) % 256;
          i++;
        end
        if (int'(s[i]) == sum) begin
          exp_v.push_back(2'b01);
          exp_pkt = sat(exp_pkt + 1);
        end else begin
          exp_v.push_back(2'b10);
          exp_err = sat(exp_err + 1);
        end
        i++;
      end
    end
  endfunction

  // kind 0: bad length, 1: bad checksum, otherwise good
  function automatic void gen_pkt(input int kind, output bq_t p);
    int len;
    int sum = 0;
    logic [7:0] b;
    p = {};
    if (kind == 0) begin
      p.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
    end else begin
      len = $urandom_range(1, MAX_LEN);
      p.push_back(8'(len));
      for (int j = 0; j < len; j++) begin
        b = 8'($urandom);
        sum += int'(b);
        p.push_back(b);
      end
      p.push_back((kind == 1) ? 8'(sum + 1 + $urandom_range(0, 254)) : 8'(sum));
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int budget = 0;
    logic acc;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) stalls++;
      budget++;
    end while (!acc && budget < 200);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%02h in_ready=0 required=1", b);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_stream(input bq_t s, input int gap_pct);
    foreach (s[k]) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      send_byte(s[k]);
    end
  endtask

  task automatic drain();
    rr = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_d.delete(); obs_v.delete(); exp_d.delete(); exp_v.delete();
    exp_pkt = 0; exp_err = 0; saw_ov = 1'b0; stalls = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out_data, out_valid, out_last, pkt_ok, pkt_err, pkt_count, err_count} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs got data=%02h v=%b l=%b ok=%b err=%b pc=%0d ec=%0d exp all 0",
               out_data, out_valid, out_last, pkt_ok, pkt_err, pkt_count, err_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_packet();
    bq_t s = '{8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    do_reset();
    out_ready = 1'b1;
    model(s);
    send_stream(s, 0);
    drain();
    checks++;
    if (obs_d.size() != 3) begin errors++; $display("FAIL good_nbytes got=%0d exp=3", obs_d.size()); end
    foreach (exp_d[k]) if (k < obs_d.size()) begin
      checks++;
      if (obs_d[k] !== exp_d[k]) begin errors++; $display("FAIL good_byte[%0d] got=%03h exp=%03h", k, obs_d[k], exp_d[k]); end
    end
    checks++;
    if (obs_v.size() != 1 || obs_v[0] !== 2'b01) begin errors++; $display("FAIL good_verdict got n=%0d exp one ok pulse", obs_v.size()); end
    checks++;
    if (pkt_count !== 16'd1 || err_count !== 16'd0) begin errors++; $display("FAIL good_counts got pc=%0d ec=%0d exp 1/0", pkt_count, err_count); end
  endtask

  task automatic test_bad_checksum();
    bq_t s = '{8'h02, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h05, 8'h05};
    do_reset();
    out_ready = 1'b1;
    model(s);
    send_stream(s, 0);
    drain();
    checks++;
    if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL badsum_nbytes got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
    foreach (exp_d[k]) if (k < obs_d.size()) begin
      checks++;
      if (obs_d[k] !== exp_d[k]) begin errors++; $display("FAIL badsum_byte[%0d] got=%03h exp=%03h", k, obs_d[k], exp_d[k]); end
    end
    checks++;
    if (obs_v.size() != 2 || obs_v[0] !== 2'b10 || obs_v[1] !== 2'b01) begin
      errors++; $display("FAIL badsum_verdicts got n=%0d exp err then ok", obs_v.size());
    end
    checks++;
    if (pkt_count !== 16'd1 || err_count !== 16'd1) begin errors++; $display("FAIL badsum_counts got pc=%0d ec=%0d exp 1/1", pkt_count, err_count); end
  endtask

  task automatic test_bad_length();
    bq_t s = '{8'h00, 8'h10};
    do_reset();
    out_ready = 1'b1;
    model(s);
    send_stream(s, 0);
    drain();
    checks++;
    if (obs_v.size() != 2 || obs_v[0] !== 2'b10 || obs_v[1] !== 2'b10) begin
      errors++; $display("FAIL badlen_verdicts got n=%0d exp two err pulses", obs_v.size());
    end
    checks++;
    if (saw_ov !== 1'b0) begin errors++; $display("FAIL badlen_out_valid got=1 exp=0"); end
    checks++;
    if (err_count !== 16'd2 || pkt_count !== 16'd0) begin errors++; $display("FAIL badlen_counts got ec=%0d pc=%0d exp 2/0", err_count, pkt_count); end
    // Still parsing lengths: a MAX_LEN packet must be accepted
    s = '{8'(MAX_LEN)};
    for (int j = 0; j < MAX_LEN; j++) s.push_back(8'd1);
    s.push_back(8'(MAX_LEN));
    model(s);
    send_stream(s, 0);
    drain();
    checks++;
    if (pkt_count !== 16'(exp_pkt) || obs_d.size() != MAX_LEN) begin
      errors++; $display("FAIL maxlen_pkt got pc=%0d nbytes=%0d exp pc=%0d nbytes=%0d", pkt_count, obs_d.size(), exp_pkt, MAX_LEN);
    end
  endtask

  task automatic test_backpressure();
    bq_t s = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    do_reset();
    model(s);
    out_ready = 1'b1;
    send_byte(8'h04);
    out_ready = 1'b0;
    send_byte(8'h01);
    in_valid = 1'b1;
    in_data  = 8'h02;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h01) begin
        errors++; $display("FAIL bp_hold[%0d] got rdy=%b v=%b d=%02h exp rdy=0 v=1 d=01", c, in_ready, out_valid, out_data);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_stream('{8'h02, 8'h03, 8'h04, 8'h0A}, 0);
    drain();
    checks++;
    if (obs_d.size() != 4) begin errors++; $display("FAIL bp_nbytes got=%0d exp=4", obs_d.size()); end
    foreach (exp_d[k]) if (k < obs_d.size()) begin
      checks++;
      if (obs_d[k] !== exp_d[k]) begin errors++; $display("FAIL bp_byte[%0d] got=%03h exp=%03h", k, obs_d[k], exp_d[k]); end
    end
    checks++;
    if (obs_v.size() != 1 || obs_v[0] !== 2'b01) begin errors++; $display("FAIL bp_verdict got n=%0d exp one ok", obs_v.size()); end
  endtask

  task automatic test_back_to_back();
    bq_t s = {};
    bq_t p;
    int c0;
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin gen_pkt(2, p); s = {s, p}; end
    model(s);
    c0 = cyc;
    send_stream(s, 0);
    checks++;
    if (stalls != 0 || (cyc - c0) != s.size()) begin
      errors++; $display("FAIL b2b_throughput got stalls=%0d cycles=%0d exp 0/%0d", stalls, cyc - c0, s.size());
    end
    drain();
    checks++;
    if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL b2b_nbytes got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
    foreach (exp_d[k]) if (k < obs_d.size()) begin
      checks++;
      if (obs_d[k] !== exp_d[k]) begin errors++; $display("FAIL b2b_byte[%0d] got=%03h exp=%03h", k, obs_d[k], exp_d[k]); end
    end
    checks++;
    if (pkt_count !== 16'(exp_pkt)) begin errors++; $display("FAIL b2b_pkt_count got=%0d exp=%0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_random();
    bq_t s = {};
    bq_t p;
    do_reset();
    for (int n = 0; n < 40; n++) begin gen_pkt($urandom_range(0, 5), p); s = {s, p}; end
    model(s);
    rr = 1'b1;
    send_stream(s, 20);
    drain();
    checks++;
    if (obs_d.size() != exp_d.size()) begin errors++; $display("FAIL rand_nbytes got=%0d exp=%0d", obs_d.size(), exp_d.size()); end
    foreach (exp_d[k]) if (k < obs_d.size()) begin
      checks++;
      if (obs_d[k] !== exp_d[k]) begin errors++; $display("FAIL rand_byte[%0d] got=%03h exp=%03h", k, obs_d[k], exp_d[k]); end
    end
    checks++;
    if (obs_v.size() != exp_v.size()) begin errors++; $display("FAIL rand_nverdicts got=%0d exp=%0d", obs_v.size(), exp_v.size()); end
    foreach (exp_v[k]) if (k < obs_v.size()) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin errors++; $display("FAIL rand_verdict[%0d] got=%b exp=%b", k, obs_v[k], exp_v[k]); end
    end
    checks++;
    if (pkt_count !== 16'(exp_pkt) || err_count !== 16'(exp_err)) begin
      errors++; $display("FAIL rand_counts got pc=%0d ec=%0d exp %0d/%0d", pkt_count, err_count, exp_pkt, exp_err);
    end
  endtask

  task automatic test_reset_midpacket();
    bq_t s = '{8'h01, 8'h7F, 8'h7F};
    do_reset();
    send_byte(8'h02);
    send_byte(8'hAA);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, out_last, pkt_ok, pkt_err, pkt_count, err_count} !== 44'd0) begin
      errors++; $display("FAIL midrst_outputs got data=%02h v=%b l=%b exp all 0", out_data, out_valid, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_d.delete(); obs_v.delete(); exp_d.delete(); exp_v.delete();
    exp_pkt = 0; exp_err = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    model(s);
    send_stream(s, 0);
    drain();
    checks++;
    if (obs_d.size() != 1 || obs_d[0] !== 9'h17F) begin errors++; $display("FAIL midrst_byte got n=%0d exp one 17f", obs_d.size()); end
    checks++;
    if (pkt_count !== 16'd1 || err_count !== 16'd0 || obs_v.size() != 1 || obs_v[0] !== 2'b01) begin
      errors++; $display("FAIL midrst_counts got pc=%0d ec=%0d nv=%0d exp 1/0/1", pkt_count, err_count, obs_v.size());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (65537) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err_count !== 16'hFFFF || pkt_count !== 16'd0) begin
      errors++; $display("FAIL sat_err_count got ec=%04h pc=%04h exp ffff/0000", err_count, pkt_count);
    end
    force dut.r_pkt_count = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.r_pkt_count;
    send_stream('{8'h01, 8'h05, 8'h05}, 0);
    drain();
    checks++;
    if (pkt_count !== 16'hFFFF) begin errors++; $display("FAIL sat_pkt_inc got=%04h exp=ffff", pkt_count); end
    send_stream('{8'h01, 8'h09, 8'h09}, 0);
    drain();
    checks++;
    if (pkt_count !== 16'hFFFF || err_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_pkt_hold got pc=%04h ec=%04h exp ffff/ffff", pkt_count, err_count);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_bad_length();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midpacket();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_rx_consumer.md
PKT_RX_CONSUMER -- requirements
Module: pkt_rx_consumer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 15, meaning the largest legal payload length in bytes (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_data  input  8  upstream byte.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port out_data  output  8  payload byte to downstream.
REQ-008 SHALL have port out_valid  output  1  out_data valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-010 SHALL have port out_last  output  1  out_data is the final payload byte of a packet.
REQ-011 SHALL have port pkt_ok  output  1  one-cycle pulse: checksum matched.
REQ-012 SHALL have port pkt_err  output  1  one-cycle pulse: bad length or checksum mismatch.
REQ-013 SHALL have port pkt_count  output  16  good packets received.
REQ-014 SHALL have port err_count  output  16  errored packets received.

Function
REQ-015 SHALL treat an input transfer as occurring at a rising edge where in_valid and in_ready are both 1; the same rule applies to out_valid/out_ready.
REQ-016 SHALL parse packets framed as: one length byte L, then L payload bytes, then one checksum byte equal to the sum of the payload bytes mod 256.
REQ-017 SHALL implement FSM states S_LEN, S_PAY, S_SUM; reset state S_LEN.
REQ-018 SHALL drive in_ready=1 in S_LEN and S_SUM, and in S_PAY in_ready = !out_valid || out_ready.
REQ-019 In S_LEN on transfer: if L==0 or L>MAX_LEN, SHALL pulse pkt_err, increment err_count and stay in S_LEN; otherwise load remaining=L, clear running sum, go to S_PAY.
REQ-020 In S_PAY on transfer: SHALL register out_data=in_data, out_valid=1, out_last=(remaining==1), add byte to 8-bit running sum (wrap mod 256), decrement remaining; when remaining was 1, go to S_SUM.
REQ-021 Payload latency SHALL be one cycle: byte accepted at edge k is presented on out_data after edge k.
REQ-022 SHALL hold out_data/out_valid/out_last stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid and out_last after an output transfer that is not accompanied by a new payload input transfer in the same cycle; simultaneous output and input transfer SHALL replace the register with no bubble.
REQ-024 In S_SUM on transfer: if checksum equals running sum, SHALL pulse pkt_ok and increment pkt_count, else pulse pkt_err and increment err_count; go to S_LEN in both cases.
REQ-025 pkt_ok/pkt_err SHALL be registered, high for exactly the one cycle after the deciding edge, and never both high.
REQ-026 pkt_count and err_count SHALL saturate at 16'hFFFF.
REQ-027 S_SUM checksum acceptance SHALL not depend on out_ready; the last payload byte may still be pending downstream when the verdict pulses.
REQ-028 SHALL ignore in_data whenever no input transfer occurs.

Reset
REQ-029 On rst_n=0, asynchronously: state=S_LEN, out_data=0, out_valid=0, out_last=0, pkt_ok=0, pkt_err=0, pkt_count=0, err_count=0, remaining=0, sum=0.
REQ-030 Reset mid-packet SHALL discard the partial packet without incrementing any counter; the first byte after release SHALL be parsed as a length byte.
REQ-031 in_ready SHALL equal 1 in the first cycle after reset release.

Verification
REQ-032 Good packet 03,10,20,30,60 with out_ready=1 -> out bytes 10,20,30 with out_last only on 30; pkt_ok one pulse; pkt_count=1, err_count=0.
REQ-033 Bad checksum 02,FF,02,00 -> bytes FF,02 delivered; pkt_err pulse; err_count=1; next packet 01,05,05 -> pkt_ok, pkt_count=1.
REQ-034 Length 00 then length 10 (16>MAX_LEN) -> two pkt_err pulses, err_count=2, no out_valid, FSM stays S_LEN.
REQ-035 Back-pressure: packet 04,01,02,03,04,0A with out_ready=0 for 5 cycles after first payload byte -> in_ready=0 while out_valid held, out_data held at 01, all four bytes delivered in order, pkt_ok.
REQ-036 Reset asserted after 02,AA (one payload byte) -> all outputs zero; after release packet 01,7F,7F -> pkt_ok, pkt_count=1, err_count=0.
REQ-037 Preloaded near-saturation (65535 good packets or forced count) plus one more good packet -> pkt_count stays 16'hFFFF.
